// File: rtl/pwm_duty_meter_if.sv
//------------------------------------------------------------------------------
// Module : pwm_duty_meter_if
// Brief  : PWM input and measurement results bundle for pwm_duty_meter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pwm_duty_meter_if #(
    parameter int CNT_W = 13
);
    logic             pwm_in;
    logic [CNT_W-1:0] duty_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             stuck_high;
    logic             stuck_low;

    modport master (
        output pwm_in,
        input  duty_cnt,
        input  period_cnt,
        input  meas_valid,
        input  stuck_high,
        input  stuck_low
    );

    modport slave (
        input  pwm_in,
        output duty_cnt,
        output period_cnt,
        output meas_valid,
        output stuck_high,
        output stuck_low
    );
endinterface

`default_nettype wire

// File: rtl/pwm_duty_meter.sv
//------------------------------------------------------------------------------
// Module : pwm_duty_meter
// Brief  : Measures high time and rise-to-rise period of a PWM input in clk
//          cycles and flags a stuck-high or stuck-low input.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pwm_duty_meter #(
    parameter int CNT_W    = 13,
    parameter int TIMEOUT  = 4000,
    parameter int FILT_LEN = 3
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pwm_duty_meter_if.slave   bus
);

    localparam int               c_FCNT_W  = $clog2(FILT_LEN + 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_SYNC    = 3'd0,
        S_HIGH    = 3'd1,
        S_LOW     = 3'd2,
        S_STUCK_H = 3'd3,
        S_STUCK_L = 3'd4
    } state_t;

    // Input conditioning
    logic                r_sync1;
    logic                r_sync2;
    logic                r_lvl;
    logic                r_lvl_known;
    logic [c_FCNT_W-1:0] r_filt_cnt;
    logic                r_rise;
    logic                r_fall;

    logic [c_FCNT_W-1:0] w_filt_inc;
    logic                w_filt_full;

    assign w_filt_inc  = r_filt_cnt + c_FCNT_W'(1);
    assign w_filt_full = (w_filt_inc == c_FCNT_W'(FILT_LEN));

    // Before the level is known, r_lvl tracks the candidate level and the
    // first settled decision is taken silently, so no edge is reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_lvl       <= 1'b0;
            r_lvl_known <= 1'b0;
            r_filt_cnt  <= '0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
        end else begin
            r_sync1 <= bus.pwm_in;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (!r_lvl_known) begin
                if (r_sync2 == r_lvl) begin
                    if (w_filt_full) begin
                        r_lvl_known <= 1'b1;
                        r_filt_cnt  <= '0;
                    end else begin
                        r_filt_cnt <= w_filt_inc;
                    end
                end else begin
                    r_lvl <= r_sync2;
                    if (FILT_LEN == 1) begin
                        r_lvl_known <= 1'b1;
                        r_filt_cnt  <= '0;
                    end else begin
                        r_filt_cnt <= c_FCNT_W'(1);
                    end
                end
            end else if (r_sync2 != r_lvl) begin
                if (w_filt_full) begin
                    r_lvl      <= r_sync2;
                    r_filt_cnt <= '0;
                    r_rise     <= r_sync2;
                    r_fall     <= ~r_sync2;
                end else begin
                    r_filt_cnt <= w_filt_inc;
                end
            end else begin
                r_filt_cnt <= '0;
            end
        end
    end

    // Measurement state machine
    state_t           r_state;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] r_period;
    logic             r_meas_valid;
    logic             r_stuck_high;
    logic             r_stuck_low;

    logic [CNT_W-1:0] w_per_inc;
    logic             w_per_hit;

    // per_cnt saturates, and a stuck flag rises on the edge it reaches TIMEOUT
    assign w_per_inc = (r_per_cnt >= c_TIMEOUT) ? c_TIMEOUT : (r_per_cnt + c_ONE);
    assign w_per_hit = (w_per_inc == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_SYNC;
            r_hi_cnt     <= '0;
            r_per_cnt    <= '0;
            r_duty       <= '0;
            r_period     <= '0;
            r_meas_valid <= 1'b0;
            r_stuck_high <= 1'b0;
            r_stuck_low  <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            case (r_state)
                S_SYNC: begin
                    if (r_rise) begin
                        r_state   <= S_HIGH;
                        r_hi_cnt  <= c_ONE;
                        r_per_cnt <= c_ONE;
                    end else if (r_fall) begin
                        r_per_cnt <= '0;
                    end else begin
                        r_per_cnt <= w_per_inc;
                        if (w_per_hit) begin
                            if (r_lvl_known && r_lvl) begin
                                r_state      <= S_STUCK_H;
                                r_stuck_high <= 1'b1;
                            end else begin
                                r_state     <= S_STUCK_L;
                                r_stuck_low <= 1'b1;
                            end
                        end
                    end
                end

                S_HIGH: begin
                    r_per_cnt <= w_per_inc;
                    if (r_fall) begin
                        r_state <= S_LOW;
                    end else begin
                        r_hi_cnt <= r_hi_cnt + c_ONE;
                        if (w_per_hit) begin
                            r_state      <= S_STUCK_H;
                            r_stuck_high <= 1'b1;
                        end
                    end
                end

                S_LOW: begin
                    if (r_rise) begin
                        r_duty       <= r_hi_cnt;
                        r_period     <= r_per_cnt;
                        r_meas_valid <= 1'b1;
                        r_hi_cnt     <= c_ONE;
                        r_per_cnt    <= c_ONE;
                        r_state      <= S_HIGH;
                    end else begin
                        r_per_cnt <= w_per_inc;
                        if (w_per_hit) begin
                            r_state     <= S_STUCK_L;
                            r_stuck_low <= 1'b1;
                        end
                    end
                end

                S_STUCK_H: begin
                    // The interrupted period is dropped; resynchronise on the next rise
                    if (r_fall) begin
                        r_state      <= S_SYNC;
                        r_stuck_high <= 1'b0;
                        r_per_cnt    <= '0;
                    end
                end

                S_STUCK_L: begin
                    if (r_rise) begin
                        r_state     <= S_HIGH;
                        r_hi_cnt    <= c_ONE;
                        r_per_cnt   <= c_ONE;
                        r_stuck_low <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_SYNC;
                end
            endcase
        end
    end

    assign bus.duty_cnt   = r_duty;
    assign bus.period_cnt = r_period;
    assign bus.meas_valid = r_meas_valid;
    assign bus.stuck_high = r_stuck_high;
    assign bus.stuck_low  = r_stuck_low;

endmodule

`default_nettype wire
